eeprom_93c45_ctrl: RTL and testbench

- Host-side master that sequences the 3-wire serial protocol of a 93C45-class EEPROM (64 x 16, x16 organisation) for the Saturn backup/SMPC side.
- Takes single-word command requests (READ, WRITE, EWEN, EWDS) and generates CS/SK/DI framing, samples DO, and polls for write completion.
- Connects directly to the E93C45 device model or to a real pin interface on the same clock domain.

---
 rtl/eeprom_93c45_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_eeprom_93c45_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eeprom_93c45_ctrl.sv
// ---------------------------------------------------------------------------
// eeprom_93c45_ctrl
//   Host-side master for a 93C45-class serial EEPROM (64 x 16 words).
//   Accepts single-word READ / WRITE / EWEN / EWDS requests. For each one it
//   builds the CS/SK/DI frame, samples DO during the read data phase, and
//   after a WRITE polls DO for the ready indication, flagging a timeout.
//
// Ports
//   CLK, RST         system clock, asynchronous active-high reset
//   REQ              command request, sampled only in IDLE
//   CMD[1:0]         0=READ 1=WRITE 2=EWEN 3=EWDS
//   ADDR[5:0]        word address (ignored for EWEN/EWDS)
//   WDATA[15:0]      write data
//   BUSY             high while a command is in progress
//   DONE             one-cycle completion pulse
//   ERR              one-cycle pulse with DONE on write-poll timeout
//   RDATA[15:0]      last word read; holds until the next READ completes
//   EE_CS/SK/DI      serial interface to the device
//   EE_DO            serial data from the device
// ---------------------------------------------------------------------------
module eeprom_93c45_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 4,
    parameter int POLL_TO = 65535
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ,
    input  logic [1:0]  CMD,
    input  logic [5:0]  ADDR,
    input  logic [15:0] WDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [15:0] RDATA,
    output logic        EE_CS,
    output logic        EE_SK,
    output logic        EE_DI,
    input  logic        EE_DO
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SHIFT_OUT, S_SHIFT_IN, S_CS_LOW, S_POLL, S_FINISH
    } state_t;

    localparam logic [1:0]  CMD_READ  = 2'd0;
    localparam logic [1:0]  CMD_WRITE = 2'd1;
    localparam logic [1:0]  CMD_EWEN  = 2'd2;
    localparam logic [16:0] LP_DIV_LAST  = 17'(CLK_DIV - 1);
    localparam logic [16:0] LP_GAP_LAST  = 17'(CS_GAP - 1);
    localparam logic [16:0] LP_POLL_LAST = 17'(POLL_TO - 1);

    state_t      r_state, w_next;
    logic [1:0]  r_cmd;
    logic [24:0] r_sout;     // start, opcode, address, data; MSB goes out first
    logic [14:0] r_sin;      // read bits collected so far (final bit joins at RDATA load)
    logic [15:0] r_rdata;
    logic [16:0] r_cnt;      // cycles within the current phase/state
    logic [4:0]  r_bit;      // completed SK periods in the current shift state
    logic        r_phase;    // 0 = SK low phase, 1 = SK high phase
    logic        r_wpend;    // a WRITE frame has been sent and still needs polling
    logic        r_err;

    logic [1:0]  w_op;
    logic [5:0]  w_addr;
    logic        w_phase_end, w_last_bit, w_poll_ok, w_poll_to;
    logic [4:0]  w_bit_last;

    // Opcode/address field built from the live inputs at acceptance time.
    always_comb begin
        w_op   = 2'b00;
        w_addr = ADDR;
        case (CMD)
            CMD_READ:  w_op = 2'b10;
            CMD_WRITE: w_op = 2'b01;
            CMD_EWEN:  w_addr = 6'b110000;
            default:   w_addr = 6'b000000;
        endcase
    end

    assign w_phase_end = (r_cnt == LP_DIV_LAST);
    assign w_bit_last  = (r_state == S_SHIFT_IN) ? 5'd15 :
                         (r_cmd == CMD_WRITE)    ? 5'd24 : 5'd8;
    assign w_last_bit  = r_phase && w_phase_end && (r_bit == w_bit_last);
    // DO is ignored for the first two poll cycles while the device turns around.
    assign w_poll_ok   = (r_cnt >= 17'd2) && EE_DO;
    assign w_poll_to   = (r_cnt == LP_POLL_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        BUSY   = 1'b1;
        DONE   = 1'b0;
        ERR    = 1'b0;
        EE_CS  = 1'b0;
        EE_SK  = 1'b0;
        EE_DI  = 1'b0;
        case (r_state)
            S_IDLE: begin
                BUSY = 1'b0;
                if (REQ) w_next = S_SETUP;
            end
            S_SETUP: begin
                EE_CS = 1'b1;
                if (w_phase_end) w_next = S_SHIFT_OUT;
            end
            S_SHIFT_OUT: begin
                EE_CS = 1'b1;
                EE_SK = r_phase;
                EE_DI = r_sout[24];
                if (w_last_bit) w_next = (r_cmd == CMD_READ) ? S_SHIFT_IN : S_CS_LOW;
            end
            S_SHIFT_IN: begin
                EE_CS = 1'b1;
                EE_SK = r_phase;
                if (w_last_bit) w_next = S_CS_LOW;
            end
            S_CS_LOW: begin
                if (r_cnt == LP_GAP_LAST) w_next = r_wpend ? S_POLL : S_FINISH;
            end
            S_POLL: begin
                EE_CS = 1'b1;
                if (w_poll_ok || w_poll_to) w_next = S_CS_LOW;
            end
            S_FINISH: begin
                BUSY   = 1'b0;
                DONE   = 1'b1;
                ERR    = r_err;
                w_next = S_IDLE;
            end
            default: begin
                BUSY   = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cmd   <= '0;
            r_sout  <= '0;
            r_sin   <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_phase <= 1'b0;
            r_wpend <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (r_state == S_IDLE && REQ) begin
                r_cmd   <= CMD;
                r_sout  <= {1'b1, w_op, w_addr, WDATA};
                r_err   <= 1'b0;
                r_wpend <= 1'b0;
            end

            if (r_state != w_next || ((r_state == S_SHIFT_OUT || r_state == S_SHIFT_IN) && w_phase_end))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 17'd1;

            if ((r_state == S_SHIFT_OUT || r_state == S_SHIFT_IN) && w_phase_end) begin
                r_phase <= ~r_phase;
                if (r_phase) begin
                    r_bit <= r_bit + 5'd1;
                    if (r_state == S_SHIFT_OUT) r_sout <= {r_sout[23:0], 1'b0};
                    else                        r_sin  <= {r_sin[13:0], EE_DO};
                end
            end
            // Every state change starts the bit/phase sequence afresh.
            if (r_state != w_next) begin
                r_bit   <= '0;
                r_phase <= 1'b0;
            end

            if (r_state == S_SHIFT_IN && w_next == S_CS_LOW)
                r_rdata <= {r_sin, EE_DO};
            if (r_state == S_SHIFT_OUT && w_next == S_CS_LOW && r_cmd == CMD_WRITE)
                r_wpend <= 1'b1;
            if (r_state == S_CS_LOW && w_next == S_POLL)
                r_wpend <= 1'b0;
            if (r_state == S_POLL && w_next == S_CS_LOW)
                r_err <= ~w_poll_ok;
        end
    end

    assign RDATA = r_rdata;

endmodule

// File: tb/tb_eeprom_93c45_ctrl.sv
module tb_eeprom_93c45_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        REQ = 1'b0;
    logic [1:0]  CMD = 2'd0;
    logic [5:0]  ADDR = 6'd0;
    logic [15:0] WDATA = 16'd0;
    logic        BUSY, DONE, ERR, EE_CS, EE_SK, EE_DI, EE_DO;
    logic [15:0] RDATA;

    eeprom_93c45_ctrl #(.CLK_DIV(4), .CS_GAP(4), .POLL_TO(100)) u_dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .CMD(CMD), .ADDR(ADDR), .WDATA(WDATA),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RDATA(RDATA),
        .EE_CS(EE_CS), .EE_SK(EE_SK), .EE_DI(EE_DI), .EE_DO(EE_DO)
    );

    always #5 CLK = ~CLK;

    // ---------------- behavioural 93C45 model (x16) ----------------
    logic [15:0] mem [64];
    logic        host_we = 1'b0;
    logic [5:0]  host_addr = 6'd0;
    logic [15:0] host_wdata = 16'd0;
    logic [15:0] host_rdata;
    logic        stub = 1'b0;
    logic        sk_q = 1'b0, mwen = 1'b0, mrd = 1'b0, mwr_rdy = 1'b0, mdo = 1'b0;
    logic [4:0]  mcnt = 5'd0;
    logic [24:0] msr = 25'd0;
    logic [15:0] mrd_sr = 16'd0;
    logic [8:0]  mnine;
    int          mbusy = 0;

    assign host_rdata = mem[host_addr];
    assign mnine      = {msr[7:0], EE_DI};
    assign EE_DO      = stub ? 1'b0 : (mrd ? mdo : (mbusy == 0));

    always @(posedge CLK) begin
        sk_q <= EE_SK;
        if (host_we) mem[host_addr] <= host_wdata;
        if (mbusy > 0) mbusy <= mbusy - 1;
        if (!EE_CS) begin
            if (mwr_rdy) begin
                if (mwen) mem[msr[21:16]] <= msr[15:0];
                mbusy <= 3;
            end
            mwr_rdy <= 1'b0;
            mcnt    <= 5'd0;
            mrd     <= 1'b0;
            msr     <= 25'd0;
        end else if (EE_SK && !sk_q) begin
            msr  <= {msr[23:0], EE_DI};
            mcnt <= mcnt + 5'd1;
            if (mrd) begin
                mdo    <= mrd_sr[15];
                mrd_sr <= {mrd_sr[14:0], 1'b0};
            end else if (mcnt == 5'd8) begin
                if (mnine[7:6] == 2'b10) begin
                    mrd    <= 1'b1;
                    mrd_sr <= mem[mnine[5:0]];
                    mdo    <= 1'b0;
                end else if (mnine[7:6] == 2'b00 && mnine[5:4] == 2'b11) begin
                    mwen <= 1'b1;
                end else if (mnine[7:6] == 2'b00 && mnine[5:4] == 2'b00) begin
                    mwen <= 1'b0;
                end
            end else if (mcnt == 5'd24 && msr[22:21] == 2'b01) begin
                mwr_rdy <= 1'b1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [15:0] rdata;
        logic        chk_rd;
        logic        err;
        int          lat;
        int          t0;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (DONE) begin
            exp_t e;
            done_cnt++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got DONE at cycle %0d, expected no completion", cyc);
            end else begin
                e = q.pop_front();
                chk("latency", cyc - e.t0, e.lat);
                chk("err", {31'd0, ERR}, {31'd0, e.err});
                chk("cs_at_done", {31'd0, EE_CS}, 32'd0);
                if (e.chk_rd) chk("rdata", {16'd0, RDATA}, {16'd0, e.rdata});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [1:0] c, input logic [5:0] a, input logic [15:0] d,
                         input bit push, input logic [15:0] exp_rd, input bit chk_rd,
                         input bit exp_err, input int lat);
        exp_t e;
        @(negedge CLK);
        CMD = c; ADDR = a; WDATA = d; REQ = 1'b1;
        if (push) begin
            e.rdata = exp_rd; e.chk_rd = chk_rd; e.err = exp_err; e.lat = lat; e.t0 = cyc;
            q.push_back(e);
        end
        @(negedge CLK);
        REQ = 1'b0;
        // Scramble the inputs so any failure to latch them shows up.
        CMD = ~c; ADDR = ~a; WDATA = ~d;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (q.size() != 0 && k < 2000) begin
            @(negedge CLK);
            k++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no DONE within 2000 cycles, expected %0d pending", q.size());
            q.delete();
        end
        @(negedge CLK);
    endtask

    task automatic host_write(input logic [5:0] a, input logic [15:0] d);
        @(negedge CLK);
        host_addr = a; host_wdata = d; host_we = 1'b1;
        @(negedge CLK);
        host_we = 1'b0;
    endtask

    initial begin
        int   dc0;
        int   nr;
        logic skp;

        #1 RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_cs",    {31'd0, EE_CS}, 32'd0);
        chk("rst_sk",    {31'd0, EE_SK}, 32'd0);
        chk("rst_di",    {31'd0, EE_DI}, 32'd0);
        chk("rst_busy",  {31'd0, BUSY},  32'd0);
        chk("rst_done",  {31'd0, DONE},  32'd0);
        chk("rst_err",   {31'd0, ERR},   32'd0);
        chk("rst_rdata", {16'd0, RDATA}, 32'd0);
        RST = 1'b0;

        host_write(6'h05, 16'hBEEF);
        host_write(6'h3F, 16'h0000);

        // Plain read of a preloaded word.
        issue(2'd0, 6'h05, 16'h0000, 1, 16'hBEEF, 1, 0, 209);
        wait_idle();

        // Enable, write, read back, and check the array directly.
        issue(2'd2, 6'h00, 16'h0000, 1, 16'h0000, 0, 0, 81);
        wait_idle();
        issue(2'd1, 6'h3F, 16'h1234, 1, 16'h0000, 0, 0, 216);
        wait_idle();
        issue(2'd0, 6'h3F, 16'h0000, 1, 16'h1234, 1, 0, 209);
        wait_idle();
        host_addr = 6'h3F;
        #1 chk("array_3f", {16'd0, host_rdata}, {16'd0, 16'h1234});

        // Disabled write completes normally but leaves the word intact.
        issue(2'd3, 6'h00, 16'h0000, 1, 16'h0000, 0, 0, 81);
        wait_idle();
        issue(2'd1, 6'h3F, 16'hFFFF, 1, 16'h0000, 0, 0, 216);
        wait_idle();
        issue(2'd0, 6'h3F, 16'h0000, 1, 16'h1234, 1, 0, 209);
        wait_idle();

        // Device never reports ready: poll times out after 100 cycles.
        stub = 1'b1;
        issue(2'd1, 6'h00, 16'h5555, 1, 16'h0000, 0, 1, 313);
        wait_idle();
        stub = 1'b0;

        // Reset in the middle of an enabled WRITE to address 5.
        issue(2'd2, 6'h00, 16'h0000, 1, 16'h0000, 0, 0, 81);
        wait_idle();
        issue(2'd1, 6'h05, 16'h0BAD, 0, 16'h0000, 0, 0, 0);
        nr = 0;
        skp = 1'b0;
        for (int k = 0; k < 500 && nr < 6; k++) begin
            @(posedge CLK);
            #1;
            if (EE_SK && !skp) nr++;
            skp = EE_SK;
        end
        chk("sk_rises_before_rst", nr, 6);
        @(negedge CLK);
        chk("busy_mid_frame", {31'd0, BUSY}, 32'd1);
        #2 RST = 1'b1;
        #1;
        chk("mid_rst_cs",    {31'd0, EE_CS}, 32'd0);
        chk("mid_rst_sk",    {31'd0, EE_SK}, 32'd0);
        chk("mid_rst_di",    {31'd0, EE_DI}, 32'd0);
        chk("mid_rst_busy",  {31'd0, BUSY},  32'd0);
        chk("mid_rst_done",  {31'd0, DONE},  32'd0);
        chk("mid_rst_err",   {31'd0, ERR},   32'd0);
        chk("mid_rst_rdata", {16'd0, RDATA}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        issue(2'd0, 6'h05, 16'h0000, 1, 16'hBEEF, 1, 0, 209);
        wait_idle();

        // A REQ pulsed while busy must be dropped.
        dc0 = done_cnt;
        issue(2'd0, 6'h3F, 16'h0000, 1, 16'h1234, 1, 0, 209);
        repeat (20) @(negedge CLK);
        CMD = 2'd0; ADDR = 6'h05; REQ = 1'b1;
        @(negedge CLK);
        REQ = 1'b0;
        wait_idle();
        repeat (300) @(negedge CLK);
        chk("single_done", done_cnt - dc0, 1);
        chk("rdata_hold", {16'd0, RDATA}, {16'd0, 16'h1234});
        chk("busy_idle", {31'd0, BUSY}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
